// File: rtl/digi_ota_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : digi_ota_scheduler_if
//  Description : Bundle of request/grant, OTA control and result-handshake
//                signals between the OTA scheduler and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface digi_ota_scheduler_if #(
    parameter int NCH   = 4,
    parameter int NSAMP = 16
);
    localparam int SW = $clog2(NCH);
    localparam int CW = $clog2(NSAMP + 1);

    logic [NCH-1:0] req;
    logic [NCH-1:0] ack;
    logic [SW-1:0]  ota_sel;
    logic           ota_en;
    logic           ota_out;
    logic           busy;
    logic           res_valid;
    logic           res_ready;
    logic [SW-1:0]  res_ch;
    logic [CW-1:0]  res_count;
    logic           res_bit;

    // Scheduler side
    modport slave (
        input  req, ota_out, res_ready,
        output ack, ota_sel, ota_en, busy, res_valid, res_ch, res_count, res_bit
    );

    // Environment side (requesters, OTA, result consumer)
    modport master (
        output req, ota_out, res_ready,
        input  ack, ota_sel, ota_en, busy, res_valid, res_ch, res_count, res_bit
    );
endinterface
`default_nettype wire

// File: rtl/digi_ota_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : digi_ota_scheduler
//  Description : Round-robin time-sharing of one OTA comparator between NCH
//                channels: grant, settle, integrate NSAMP synchronized
//                comparator samples, return ones-count and majority bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module digi_ota_scheduler #(
    parameter int NCH        = 4,
    parameter int SETTLE_CYC = 4,
    parameter int NSAMP      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digi_ota_scheduler_if.slave   bus
);
    localparam int SW  = $clog2(NCH);
    localparam int CW  = $clog2(NSAMP + 1);
    localparam int STW = $clog2(SETTLE_CYC);
    localparam int SNW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_SETTLE = 2'd1;
    localparam logic [1:0] C_SAMPLE = 2'd2;
    localparam logic [1:0] C_DONE   = 2'd3;

    logic [1:0]     r_state;
    logic [SW-1:0]  r_last;
    logic [NCH-1:0] r_ack;
    logic [SW-1:0]  r_sel;
    logic           r_en;
    logic           r_busy;
    logic           r_valid;
    logic [CW-1:0]  r_count;
    logic           r_bit;
    logic [STW-1:0] r_settle;
    logic [SNW-1:0] r_samp;
    logic           r_sync1;
    logic           r_sync2;

    logic           w_found;
    logic [SW-1:0]  w_idx;
    logic [SW:0]    w_k;
    logic [CW-1:0]  w_sum;

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.ota_out;
            r_sync2 <= r_sync1;
        end
    end

    // Round-robin search: first requesting index strictly after r_last, wrapping.
    // Iterating the offset downward lets the nearest requester win.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_k = {1'b0, r_last} + (SW+1)'(i);
            if (w_k >= (SW+1)'(NCH)) begin
                w_k = w_k - (SW+1)'(NCH);
            end
            if (bus.req[w_k[SW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_k[SW-1:0];
            end
        end
    end

    // Accumulator value including the sample taken on this edge
    assign w_sum = r_count + CW'(r_sync2);

    // Conversion sequencer: grant, settle, sample, hold result until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= C_IDLE;
            r_last   <= SW'(NCH - 1);
            r_ack    <= '0;
            r_sel    <= '0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_bit    <= 1'b0;
            r_settle <= '0;
            r_samp   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                C_IDLE: begin
                    if (w_found) begin
                        r_state       <= C_SETTLE;
                        r_busy        <= 1'b1;
                        r_sel         <= w_idx;
                        r_last        <= w_idx;
                        r_ack[w_idx]  <= 1'b1;
                        r_en          <= 1'b1;
                        r_count       <= '0;
                        r_settle      <= STW'(SETTLE_CYC - 1);
                    end
                end
                C_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= C_SAMPLE;
                        r_samp  <= SNW'(NSAMP - 1);
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                C_SAMPLE: begin
                    r_count <= w_sum;
                    if (r_samp == '0) begin
                        r_state <= C_DONE;
                        r_en    <= 1'b0;
                        r_valid <= 1'b1;
                        // Strictly greater than floor(NSAMP/2): a tie resolves to 0
                        r_bit   <= (w_sum > CW'(NSAMP / 2));
                    end else begin
                        r_samp <= r_samp - 1'b1;
                    end
                end
                C_DONE: begin
                    if (r_valid && bus.res_ready) begin
                        r_state <= C_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                    r_busy  <= 1'b0;
                    r_en    <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.ota_sel   = r_sel;
    assign bus.ota_en    = r_en;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_valid;
    assign bus.res_ch    = r_sel;
    assign bus.res_count = r_count;
    assign bus.res_bit   = r_bit;

endmodule
`default_nettype wire

// File: tb/tb_digi_ota_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digi_ota_scheduler
//  Description : Randomized scoreboard bench for digi_ota_scheduler with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digi_ota_scheduler;
    localparam int NCH  = 4;
    localparam int S    = 4;
    localparam int N    = 16;
    localparam int NCYC = 900;

    typedef struct {
        int ch;
        int cnt;
        int bitv;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    digi_ota_scheduler_if #(.NCH(NCH), .NSAMP(N)) bus ();

    digi_ota_scheduler #(
        .NCH        (NCH),
        .SETTLE_CYC (S),
        .NSAMP      (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    res_t res_q[$];
    int   ack_q[$];
    bit   ota_arr [0:NCYC+63];

    // reference model: 0 idle, 1 converting (ota enabled), 2 result waiting
    int m_state = 0;
    int m_e0    = 0;
    int m_last  = NCH - 1;
    bit exp_busy  = 1'b0;
    bit exp_en    = 1'b0;
    bit exp_valid = 1'b0;

    bit rst_done  = 1'b0;
    bit drop_done = 1'b0;
    bit fin       = 1'b0;
    int rst_hold  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_checks();
        check("rst_ack",       int'(bus.ack), 0);
        check("rst_ota_sel",   int'(bus.ota_sel), 0);
        check("rst_ota_en",    int'(bus.ota_en), 0);
        check("rst_busy",      int'(bus.busy), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_ch",    int'(bus.res_ch), 0);
        check("rst_res_count", int'(bus.res_count), 0);
        check("rst_res_bit",   int'(bus.res_bit), 0);
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_last    = NCH - 1;
        exp_busy  = 1'b0;
        exp_en    = 1'b0;
        exp_valid = 1'b0;
        ack_q.delete();
        res_q.delete();
    endtask

    // One clock edge t of the reference model, using the inputs in effect at t
    task automatic model_step(input int t);
        int ch;
        int cnt;
        res_t r;
        case (m_state)
            0: begin
                if (bus.req != '0) begin
                    ch = m_last;
                    for (int i = NCH; i >= 1; i--) begin
                        if (bus.req[(m_last + i) % NCH]) ch = (m_last + i) % NCH;
                    end
                    // sample at edge k sees ota_out that was present at edge k-2
                    cnt = 0;
                    for (int j = t + S - 1; j <= t + S + N - 2; j++) cnt += int'(ota_arr[j]);
                    r.ch   = ch;
                    r.cnt  = cnt;
                    r.bitv = (cnt > N / 2) ? 1 : 0;
                    ack_q.push_back(ch);
                    res_q.push_back(r);
                    m_last  = ch;
                    m_e0    = t;
                    m_state = 1;
                end
            end
            1: if (t == m_e0 + S + N) m_state = 2;
            default: if (bus.res_ready) m_state = 0;
        endcase
        exp_busy  = (m_state != 0);
        exp_en    = (m_state == 1);
        exp_valid = (m_state == 2);
    endtask

    function automatic logic [NCH-1:0] req_for(input int c);
        if (c < 60)             return 4'b0100;
        else if (c < 200)       return 4'b1111;
        else if (c < 320)       return 4'b1010;
        else if (c < 380)       return drop_done ? 4'b0000 : 4'b0010;
        else if (c >= NCYC - 80) return 4'b0000;
        else if (rst_done)      return 4'b1111;
        else                    return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic rdy_for(input int c);
        if (c < 380 || c >= NCYC - 80) return 1'b1;
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Monitor: compares DUT outputs against model and scoreboard queues
    initial begin
        int   e;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && !fin) begin
                check("busy",      int'(bus.busy), int'(exp_busy));
                check("ota_en",    int'(bus.ota_en), int'(exp_en));
                check("res_valid", int'(bus.res_valid), int'(exp_valid));
                if (bus.ack != '0) begin
                    if (ack_q.size() == 0) begin
                        check("ack_unexpected", int'(bus.ack), 0);
                    end else begin
                        e = ack_q.pop_front();
                        check("ack",     int'(bus.ack), 1 << e);
                        check("ota_sel", int'(bus.ota_sel), e);
                    end
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (res_q.size() == 0) begin
                        check("res_unexpected", int'(bus.res_valid), 0);
                    end else begin
                        r = res_q.pop_front();
                        check("res_ch",    int'(bus.res_ch), r.ch);
                        check("res_count", int'(bus.res_count), r.cnt);
                        check("res_bit",   int'(bus.res_bit), r.bitv);
                    end
                end
            end
        end
    end

    // Stimulus driver
    initial begin
        for (int c = 0; c < NCYC + 64; c++) begin
            if (c < 60)       ota_arr[c] = 1'b1;
            else if (c < 200) ota_arr[c] = c[0];
            else              ota_arr[c] = 1'($urandom_range(0, 1));
        end
        bus.req       = '0;
        bus.ota_out   = 1'b0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1 reset_checks();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            bus.req       = req_for(cyc);
            bus.ota_out   = ota_arr[cyc];
            bus.res_ready = rdy_for(cyc);
            @(posedge clk);
            if (rst_n) model_step(cyc);
            // drop channel 1's request while its conversion is settling
            if (cyc >= 320 && cyc < 380 && m_state == 1 && m_last == 1) drop_done = 1'b1;
            #2;
            if (!rst_done && cyc >= 620 && cyc < NCYC - 100 && m_state == 1 &&
                cyc >= m_e0 + S + 1 && cyc < m_e0 + S + N) begin
                rst_n = 1'b0;
                #1 reset_checks();
                model_reset();
                rst_done = 1'b1;
                rst_hold = 3;
            end else if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end
        end

        @(negedge clk);
        fin = 1'b1;
        check("ack_queue_empty", ack_q.size(), 0);
        check("res_queue_empty", res_q.size(), 0);
        check("reset_injected",  int'(rst_done), 1);
        check("drop_exercised",  int'(drop_done), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
